// File: rtl/instr_decode_stage.sv
// Registered RV32I-subset decode stage between fetch and execute, with valid/ready on both sides and flush.
// Optional macro DECODE_ILLEGAL_FLAG_EN registers out_illegal for unsupported encodings; otherwise it reads 0.
module instr_decode_stage #(
    parameter int XLEN = 32,
    parameter int PCW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [PCW-1:0]  in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PCW-1:0]  out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_alu_op,
    output logic            out_alu_src_imm,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_branch_ne,
    output logic            out_jump,
    output logic            out_illegal,
    output logic [31:0]     decoded_count
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD      = 3'd0;
    localparam logic [2:0] ALU_SUB      = 3'd1;
    localparam logic [2:0] ALU_AND      = 3'd2;
    localparam logic [2:0] ALU_OR       = 3'd3;
    localparam logic [2:0] ALU_PASS_IMM = 3'd4;

    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      alu_op;
        logic            alu_src_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            branch_ne;
        logic            jump;
        logic            illegal;
    } bundle_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic            legal;
    bundle_t         dec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    // Combinational decode of the word on the input side; only captured on accept.
    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        dec.rs1   = in_instr[19:15];
        dec.rs2   = in_instr[24:20];
        dec.alu_op = ALU_ADD;
        case (opcode)
            OP_REG: begin
                dec.reg_write = 1'b1;
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec.alu_op = ALU_ADD;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec.alu_op = ALU_SUB;
                end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
                    dec.alu_op = ALU_AND;
                end else if (funct3 == 3'b110 && funct7 == 7'b0000000) begin
                    dec.alu_op = ALU_OR;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_IMM: begin
                legal           = (funct3 == 3'b000);
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
            end
            OP_LOAD: begin
                legal           = (funct3 == 3'b010);
                dec.reg_write   = 1'b1;
                dec.mem_read    = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
            end
            OP_STORE: begin
                legal           = (funct3 == 3'b010);
                dec.mem_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_s;
            end
            OP_BRANCH: begin
                legal          = (funct3 == 3'b000) || (funct3 == 3'b001);
                dec.branch     = 1'b1;
                dec.branch_ne  = funct3[0];
                dec.alu_op     = ALU_SUB;
                dec.imm        = imm_b;
            end
            OP_LUI: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.alu_op      = ALU_PASS_IMM;
                dec.imm         = imm_u;
                dec.rs1         = '0;
                dec.rs2         = '0;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.imm       = imm_j;
                dec.rs1       = '0;
                dec.rs2       = '0;
            end
            default: legal = 1'b0;
        endcase

        // Unsupported words collapse to a harmless NOP bundle.
        if (!legal) begin
            dec = '0;
        end
        dec.rd = dec.reg_write ? in_instr[11:7] : 5'd0;
        dec.pc = in_pc;
`ifdef DECODE_ILLEGAL_FLAG_EN
        dec.illegal = !legal;
`else
        dec.illegal = 1'b0;
`endif
    end

    logic        out_valid_q, out_valid_d;
    bundle_t     bundle_q, bundle_d;
    logic [31:0] count_q, count_d;
    logic        accept;
    logic        handshake;

    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        accept      = in_valid && in_ready;
        handshake   = out_valid_q && out_ready;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        count_d     = count_q + {31'd0, handshake};
        // Flush wins over accept; a handshake in the same cycle is still counted above.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (handshake) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            count_q     <= count_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pc          = bundle_q.pc;
    assign out_rd          = bundle_q.rd;
    assign out_rs1         = bundle_q.rs1;
    assign out_rs2         = bundle_q.rs2;
    assign out_imm         = bundle_q.imm;
    assign out_alu_op      = bundle_q.alu_op;
    assign out_alu_src_imm = bundle_q.alu_src_imm;
    assign out_reg_write   = bundle_q.reg_write;
    assign out_mem_read    = bundle_q.mem_read;
    assign out_mem_write   = bundle_q.mem_write;
    assign out_branch      = bundle_q.branch;
    assign out_branch_ne   = bundle_q.branch_ne;
    assign out_jump        = bundle_q.jump;
    assign out_illegal     = bundle_q.illegal;
    assign decoded_count   = count_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed literal checks plus randomized traffic against a mnemonic-level reference model.
module tb_instr_decode_stage;

`ifdef DECODE_ILLEGAL_FLAG_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic [2:0]  out_alu_op;
    logic        out_alu_src_imm, out_reg_write, out_mem_read, out_mem_write;
    logic        out_branch, out_branch_ne, out_jump, out_illegal;
    logic [31:0] decoded_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_alu_src_imm(out_alu_src_imm),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_branch(out_branch),
        .out_branch_ne(out_branch_ne), .out_jump(out_jump),
        .out_illegal(out_illegal), .decoded_count(decoded_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [2:0]  alu;
        logic        src, rw, mr, mw, br, bne, jmp, ill;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: classify by mnemonic, then apply that instruction's documented behaviour.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        string m;
        int unsigned op, f3, f7, sgn;
        op  = w & 32'h7F;
        f3  = (w >> 12) & 7;
        f7  = w >> 25;
        sgn = w[31] ? 32'hFFFFFFFF : 32'h0;
        m = "ILLEGAL";
        if (op == 'h33 && f3 == 0 && f7 == 'h00) m = "ADD";
        if (op == 'h33 && f3 == 0 && f7 == 'h20) m = "SUB";
        if (op == 'h33 && f3 == 7 && f7 == 'h00) m = "AND";
        if (op == 'h33 && f3 == 6 && f7 == 'h00) m = "OR";
        if (op == 'h13 && f3 == 0) m = "ADDI";
        if (op == 'h03 && f3 == 2) m = "LW";
        if (op == 'h23 && f3 == 2) m = "SW";
        if (op == 'h63 && f3 == 0) m = "BEQ";
        if (op == 'h63 && f3 == 1) m = "BNE";
        if (op == 'h37) m = "LUI";
        if (op == 'h6F) m = "JAL";
        e = '0;
        if (m == "ILLEGAL") begin
            e.ill = ILL_EN;
            return e;
        end
        e.rd  = (w >> 7) & 31;
        e.rs1 = (w >> 15) & 31;
        e.rs2 = (w >> 20) & 31;
        case (m)
            "ADD":  e.rw = 1;
            "SUB":  begin e.rw = 1; e.alu = 1; end
            "AND":  begin e.rw = 1; e.alu = 2; end
            "OR":   begin e.rw = 1; e.alu = 3; end
            "ADDI": begin e.rw = 1; e.src = 1; e.imm = (sgn << 12) | (w >> 20); end
            "LW":   begin e.rw = 1; e.mr = 1; e.src = 1; e.imm = (sgn << 12) | (w >> 20); end
            "SW":   begin e.mw = 1; e.src = 1; e.imm = (sgn << 12) | ((w >> 25) << 5) | ((w >> 7) & 31); end
            "BEQ", "BNE": begin
                e.br = 1; e.bne = (m == "BNE"); e.alu = 1;
                e.imm = (sgn << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
            end
            "LUI":  begin e.rw = 1; e.src = 1; e.alu = 4; e.imm = w & 32'hFFFFF000; e.rs1 = 0; e.rs2 = 0; end
            "JAL":  begin
                e.rw = 1; e.jmp = 1; e.rs1 = 0; e.rs2 = 0;
                e.imm = (sgn << 20) | (w & 32'h000FF000) | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
            end
            default: ;
        endcase
        if (!e.rw) e.rd = 0;
        return e;
    endfunction

    // Model state: what the stage must be presenting after each edge.
    bit          m_valid = 0;
    int unsigned m_count = 0;
    exp_t        m_b = '0;

    always @(posedge clk or posedge rst) begin
        bit hs, acc;
        if (rst) begin
            m_valid = 0;
            m_count = 0;
            m_b = '0;
        end else begin
            hs  = m_valid && out_ready;
            acc = in_valid && (!m_valid || out_ready);
            if (hs) m_count++;
            if (flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1;
                m_b = ref_decode(in_instr);
                m_b.pc = in_pc;
            end else if (hs) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
            chk("count", decoded_count, m_count);
            if (m_valid) begin
                chk("pc", out_pc, m_b.pc);
                chk("rd", {27'd0, out_rd}, {27'd0, m_b.rd});
                chk("rs1", {27'd0, out_rs1}, {27'd0, m_b.rs1});
                chk("rs2", {27'd0, out_rs2}, {27'd0, m_b.rs2});
                chk("imm", out_imm, m_b.imm);
                chk("ctl", {21'd0, out_alu_op, out_alu_src_imm, out_reg_write, out_mem_read,
                            out_mem_write, out_branch, out_branch_ne, out_jump, out_illegal},
                           {21'd0, m_b.alu, m_b.src, m_b.rw, m_b.mr, m_b.mw, m_b.br,
                            m_b.bne, m_b.jmp, m_b.ill});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 12);
        case (k)
            0:  begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h00; end
            1:  begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
            2:  begin w[6:0] = 7'h33; w[14:12] = 3'd7; w[31:25] = 7'h00; end
            3:  begin w[6:0] = 7'h33; w[14:12] = 3'd6; w[31:25] = 7'h00; end
            4:  begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
            5:  begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
            6:  begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
            7:  begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
            8:  begin w[6:0] = 7'h63; w[14:12] = 3'd1; end
            9:  w[6:0] = 7'h37;
            10: w[6:0] = 7'h6F;
            11: w[6:0] = 7'h33;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        // Reset state, observed while rst is held.
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_count", decoded_count, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_ctl", {27'd0, out_reg_write, out_jump, out_illegal, out_rd[1:0]}, 32'd0);
        #11 rst = 1'b0;

        step();
        in_valid = 1; in_pc = 0; in_instr = 32'h2D900093; out_ready = 1;
        step();
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_rd", {27'd0, out_rd}, 32'd1);
        chk("addi_rs1", {27'd0, out_rs1}, 32'd0);
        chk("addi_imm", out_imm, 32'd729);
        chk("addi_ctl", {27'd0, out_alu_op, out_alu_src_imm, out_reg_write}, 32'b00011);
        in_instr = 32'h401103B3; in_pc = 1;
        step();
        chk("sub_regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, 5'd7, 5'd2, 5'd1});
        chk("sub_alu", {29'd0, out_alu_op}, 32'd1);
        in_instr = 32'h0000F7B7; in_pc = 2;
        step();
        chk("lui_rd", {27'd0, out_rd}, 32'd15);
        chk("lui_imm", out_imm, 32'h0000F000);
        in_instr = 32'h00562323; in_pc = 3;
        step();
        chk("sw_regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, 5'd0, 5'd12, 5'd5});
        chk("sw_imm", out_imm, 32'd6);
        in_valid = 0;
        step();
        chk("stream_count", decoded_count, 32'd4);

        // Backpressure with JAL held; a waiting ADD must not slip in.
        out_ready = 0; in_valid = 1; in_instr = 32'hFFDFFFEF; in_pc = 5;
        step();
        in_instr = 32'h003100B3; in_pc = 6;
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_jal_rd", {27'd0, out_rd}, 32'd31);
            chk("bp_jal_jump", {31'd0, out_jump}, 32'd1);
            chk("bp_jal_imm", out_imm, 32'hFFFFFFFC);
            step();
        end
        out_ready = 1;
        step();
        chk("release_rs2", {27'd0, out_rs2}, 32'd3);
        chk("release_count", decoded_count, 32'd5);

        // Flush while holding a valid bundle with a new word offered.
        out_ready = 0; flush = 1; in_instr = 32'h0000A103; in_pc = 7;
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_count", decoded_count, 32'd5);
        flush = 0; in_valid = 0;
        step();
        chk("flush_gone", {31'd0, out_valid}, 32'd0);

        // Illegal word becomes a NOP bundle.
        in_valid = 1; out_ready = 1; in_instr = 32'h0000707F; in_pc = 8;
        step();
        in_valid = 0;
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_rw", {31'd0, out_reg_write}, 32'd0);
        chk("ill_imm", out_imm, 32'd0);
        chk("ill_flag", {31'd0, out_illegal}, {31'd0, ILL_EN});

        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            step();
        end

        // Asynchronous reset between edges while a bundle is held.
        flush = 0; in_valid = 1; out_ready = 0; in_instr = 32'h2D900093;
        step();
        in_valid = 0;
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_count", decoded_count, 32'd0);
        chk("arst_imm", out_imm, 32'd0);
        chk("arst_rd", {27'd0, out_rd}, 32'd0);
        #2 rst = 1'b0;
        step();
        step();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
